// File: rtl/gravsim_pkg.sv
// Shared definitions for the GravSim register file and its step master:
// register word offsets, body limit, sequencer states and shadow field selects.
package gravsim_pkg;

    localparam logic [7:0] REG_NUM   = 8'd1;
    localparam logic [7:0] REG_START = 8'd2;
    localparam logic [7:0] REG_DONE  = 8'd3;
    localparam logic [7:0] REG_POS_X = 8'd23;
    localparam logic [7:0] REG_POS_Y = 8'd33;
    localparam logic [7:0] REG_POS_Z = 8'd43;

    localparam int MAX_BODIES = 10;

    localparam logic [1:0] FLD_X = 2'd0;
    localparam logic [1:0] FLD_Y = 2'd1;
    localparam logic [1:0] FLD_Z = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_NUM,
        ST_WR_START,
        ST_POLL,
        ST_WAIT,
        ST_WR_CLR,
        ST_RD_POS,
        ST_FIN
    } state_t;

    // Bodies are numbered 1..MAX_BODIES, so the body index adds straight onto the base.
    function automatic logic [7:0] pos_addr(input logic [3:0] idx, input logic [1:0] fld);
        logic [7:0] base;
        case (fld)
            FLD_X:   base = REG_POS_X;
            FLD_Y:   base = REG_POS_Y;
            default: base = REG_POS_Z;
        endcase
        return base + {4'd0, idx};
    endfunction

endpackage

// File: rtl/gravsim_avm_port.sv
// Single-transaction Avalon-MM holder: registers one command and holds it
// until the slave drops WAITREQUEST, then reports done with the read word.
module gravsim_avm_port (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        load,
    input  logic [7:0]  load_addr,
    input  logic        load_rd,
    input  logic        load_wr,
    input  logic [31:0] load_data,
    output logic        done,
    output logic [31:0] rd_data,
    output logic [7:0]  AVM_ADDR,
    output logic        AVM_READ,
    output logic        AVM_WRITE,
    output logic [3:0]  AVM_BYTE_EN,
    output logic [31:0] AVM_WRITEDATA,
    input  logic [31:0] AVM_READDATA,
    input  logic        AVM_WAITREQUEST
);

    logic active;

    // Done is combinational so the next command can be loaded on the same edge.
    assign done        = active & ~AVM_WAITREQUEST;
    assign rd_data     = AVM_READDATA;
    assign AVM_BYTE_EN = active ? 4'b1111 : 4'b0000;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            active        <= 1'b0;
            AVM_ADDR      <= '0;
            AVM_READ      <= 1'b0;
            AVM_WRITE     <= 1'b0;
            AVM_WRITEDATA <= '0;
        end else if (load) begin
            active        <= 1'b1;
            AVM_ADDR      <= load_addr;
            AVM_READ      <= load_rd;
            AVM_WRITE     <= load_wr;
            AVM_WRITEDATA <= load_data;
        end else if (done) begin
            active    <= 1'b0;
            AVM_READ  <= 1'b0;
            AVM_WRITE <= 1'b0;
        end
    end

endmodule

// File: rtl/gravsim_step_master.sv
// Hardware step sequencer for the GravSim register file with a local position shadow.
// Optional poll timeout enabled by defining GRAVSIM_MASTER_TIMEOUT_EN.
module gravsim_step_master
    import gravsim_pkg::*;
#(
    parameter int POLL_GAP       = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STEP_REQ,
    output logic        BUSY,
    output logic        STEP_DONE,
    output logic        ERROR,
    output logic [3:0]  NUM_OUT,
    input  logic [3:0]  SH_IDX,
    input  logic [1:0]  SH_SEL,
    output logic [31:0] SH_DATA,
    output logic [7:0]  AVM_ADDR,
    output logic        AVM_READ,
    output logic        AVM_WRITE,
    output logic [3:0]  AVM_BYTE_EN,
    output logic [31:0] AVM_WRITEDATA,
    input  logic [31:0] AVM_READDATA,
    input  logic        AVM_WAITREQUEST
);

    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

    state_t      state, state_nxt;
    logic        load, ld_rd, ld_wr, done, accept, abort, to_hit;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data, rd_data;
    logic [15:0] gap_cnt;
    logic [3:0]  body_idx, idx_nxt;
    logic [1:0]  fld, fld_nxt;
    logic        last_read;
    logic [31:0] shadow [MAX_BODIES][3];

    gravsim_avm_port u_port (
        .CLK             (CLK),
        .RESET           (RESET),
        .load            (load),
        .load_addr       (ld_addr),
        .load_rd         (ld_rd),
        .load_wr         (ld_wr),
        .load_data       (ld_data),
        .done            (done),
        .rd_data         (rd_data),
        .AVM_ADDR        (AVM_ADDR),
        .AVM_READ        (AVM_READ),
        .AVM_WRITE       (AVM_WRITE),
        .AVM_BYTE_EN     (AVM_BYTE_EN),
        .AVM_WRITEDATA   (AVM_WRITEDATA),
        .AVM_READDATA    (AVM_READDATA),
        .AVM_WAITREQUEST (AVM_WAITREQUEST)
    );

    assign BUSY      = (state != ST_IDLE);
    assign STEP_DONE = (state == ST_FIN);
    assign idx_nxt   = (fld == FLD_Z) ? body_idx + 4'd1 : body_idx;
    assign fld_nxt   = (fld == FLD_Z) ? FLD_X : fld + 2'd1;
    assign last_read = (fld == FLD_Z) && (body_idx == NUM_OUT);

`ifdef GRAVSIM_MASTER_TIMEOUT_EN
    logic [19:0] to_cnt;
    logic        err_q;

    assign to_hit = (to_cnt >= 20'(TIMEOUT_CYCLES));
    assign ERROR  = err_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if ((state == ST_POLL || state == ST_WAIT) && !to_hit)
                to_cnt <= to_cnt + 20'd1;
            if (abort)
                err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign to_hit         = 1'b0;
    assign ERROR          = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ld_addr   = '0;
        ld_rd     = 1'b0;
        ld_wr     = 1'b0;
        ld_data   = '0;
        accept    = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: if (STEP_REQ) begin
                accept = 1'b1; load = 1'b1; ld_addr = REG_NUM; ld_rd = 1'b1;
                state_nxt = ST_RD_NUM;
            end
            ST_RD_NUM: if (done) begin
                load = 1'b1; ld_addr = REG_START; ld_wr = 1'b1; ld_data = 32'd1;
                state_nxt = ST_WR_START;
            end
            ST_WR_START: if (done) begin
                load = 1'b1; ld_addr = REG_DONE; ld_rd = 1'b1;
                state_nxt = ST_POLL;
            end
            ST_POLL: if (done) begin
                if (rd_data[0] || to_hit) begin
                    abort = ~rd_data[0];
                    load = 1'b1; ld_addr = REG_START; ld_wr = 1'b1;
                    state_nxt = ST_WR_CLR;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (to_hit) begin
                    abort = 1'b1;
                    load = 1'b1; ld_addr = REG_START; ld_wr = 1'b1;
                    state_nxt = ST_WR_CLR;
                end else if (gap_cnt == GAP_LAST) begin
                    load = 1'b1; ld_addr = REG_DONE; ld_rd = 1'b1;
                    state_nxt = ST_POLL;
                end
            end
            ST_WR_CLR: if (done) begin
                if (ERROR || NUM_OUT == 4'd0) begin
                    state_nxt = ST_FIN;
                end else begin
                    load = 1'b1; ld_addr = pos_addr(4'd1, FLD_X); ld_rd = 1'b1;
                    state_nxt = ST_RD_POS;
                end
            end
            ST_RD_POS: if (done) begin
                if (last_read) begin
                    state_nxt = ST_FIN;
                end else begin
                    load = 1'b1; ld_addr = pos_addr(idx_nxt, fld_nxt); ld_rd = 1'b1;
                end
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Per-step bookkeeping: body count, poll gap timer, position cursor and shadow.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            NUM_OUT  <= '0;
            gap_cnt  <= '0;
            body_idx <= 4'd1;
            fld      <= FLD_X;
            for (int b = 0; b < MAX_BODIES; b++)
                for (int f = 0; f < 3; f++)
                    shadow[b][f] <= '0;
        end else begin
            if (state == ST_RD_NUM && done)
                NUM_OUT <= (rd_data > 32'd10) ? 4'd10 : rd_data[3:0];
            if (state == ST_WAIT) gap_cnt <= gap_cnt + 16'd1;
            else                  gap_cnt <= '0;
            if (state == ST_WR_CLR && load) begin
                body_idx <= 4'd1;
                fld      <= FLD_X;
            end
            if (state == ST_RD_POS && done) begin
                shadow[body_idx - 4'd1][fld] <= rd_data;
                body_idx <= idx_nxt;
                fld      <= fld_nxt;
            end
        end
    end

    always_comb begin
        SH_DATA = '0;
        if (SH_IDX >= 4'd1 && SH_IDX <= 4'd10 && SH_SEL != 2'd3)
            SH_DATA = shadow[SH_IDX - 4'd1][SH_SEL];
    end

endmodule

// File: tb/tb_gravsim_step_master.sv
// Directed bench for gravsim_step_master against a small behavioural register-file slave.
`timescale 1ns/1ps
module tb_gravsim_step_master;

    logic        CLK = 1'b0;
    logic        RESET, STEP_REQ;
    logic        BUSY, STEP_DONE, ERROR;
    logic [3:0]  NUM_OUT, SH_IDX;
    logic [1:0]  SH_SEL;
    logic [31:0] SH_DATA;
    logic [7:0]  AVM_ADDR;
    logic        AVM_READ, AVM_WRITE, AVM_WAITREQUEST;
    logic [3:0]  AVM_BYTE_EN;
    logic [31:0] AVM_WRITEDATA, AVM_READDATA;

    gravsim_step_master #(.POLL_GAP(4), .TIMEOUT_CYCLES(50)) dut (
        .CLK(CLK), .RESET(RESET), .STEP_REQ(STEP_REQ), .BUSY(BUSY),
        .STEP_DONE(STEP_DONE), .ERROR(ERROR), .NUM_OUT(NUM_OUT),
        .SH_IDX(SH_IDX), .SH_SEL(SH_SEL), .SH_DATA(SH_DATA),
        .AVM_ADDR(AVM_ADDR), .AVM_READ(AVM_READ), .AVM_WRITE(AVM_WRITE),
        .AVM_BYTE_EN(AVM_BYTE_EN), .AVM_WRITEDATA(AVM_WRITEDATA),
        .AVM_READDATA(AVM_READDATA), .AVM_WAITREQUEST(AVM_WAITREQUEST)
    );

    always #10 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Slave model: NUM and DONE are bench-controlled, positions are pos_bias + address.
    logic [31:0] num_val  = 32'd2;
    logic [31:0] pos_bias = 32'h1000_0000;
    int          poll_cnt = 0, poll_base = 0, done_after = 0;
    logic        start_reg = 1'b0;
    logic [7:0]  la [0:2047];
    logic        lw [0:2047];
    logic [31:0] ld [0:2047];
    int          log_n = 0, lbase = 0;

    always @* begin
        case (AVM_ADDR)
            8'd1:    AVM_READDATA = num_val;
            8'd2:    AVM_READDATA = {31'd0, start_reg};
            8'd3:    AVM_READDATA = ((poll_cnt - poll_base) >= done_after) ? 32'd1 : 32'd0;
            default: AVM_READDATA = pos_bias + 32'(AVM_ADDR);
        endcase
    end

    always @(posedge CLK) begin
        if (!RESET && !AVM_WAITREQUEST && (AVM_READ || AVM_WRITE)) begin
            if (log_n < 2048) begin
                la[log_n] <= AVM_ADDR;
                lw[log_n] <= AVM_WRITE;
                ld[log_n] <= AVM_WRITEDATA;
            end
            log_n <= log_n + 1;
            if (AVM_WRITE && AVM_ADDR == 8'd2) start_reg <= AVM_WRITEDATA[0];
            if (AVM_READ && AVM_ADDR == 8'd3) poll_cnt <= poll_cnt + 1;
        end
    end

    task automatic start_step();
        @(negedge CLK);
        poll_base = poll_cnt;
        lbase     = log_n;
        STEP_REQ  = 1'b1;
        t0        = cyc;
        @(negedge CLK);
        STEP_REQ  = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit tmo);
        lat = -1;
        tmo = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (STEP_DONE) begin
                lat = cyc - t0;
                tmo = 1'b0;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", BUSY); end
        n_checks++; if (STEP_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_step_done got %0b want 0", STEP_DONE); end
        n_checks++; if (ERROR !== 1'b0) begin n_fail++; $display("FAIL reset_error got %0b want 0", ERROR); end
        n_checks++; if (NUM_OUT !== 4'd0) begin n_fail++; $display("FAIL reset_num got %0d want 0", NUM_OUT); end
        n_checks++; if ({AVM_READ, AVM_WRITE, AVM_BYTE_EN} !== 6'd0) begin n_fail++; $display("FAIL reset_bus got %b want 000000", {AVM_READ, AVM_WRITE, AVM_BYTE_EN}); end
        SH_IDX = 4'd1; SH_SEL = 2'd0; #1;
        n_checks++; if (SH_DATA !== 32'd0) begin n_fail++; $display("FAIL reset_shadow got %h want 0", SH_DATA); end
    endtask

    task automatic test_basic();
        int lat; bit tmo;
        logic [7:0] exp_a [10] = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd24, 8'd34, 8'd44, 8'd25, 8'd35, 8'd45};
        num_val = 32'd2; pos_bias = 32'h1000_0000; done_after = 0;
        start_step();
        n_checks++; if (BUSY !== 1'b1 || AVM_READ !== 1'b1 || AVM_ADDR !== 8'd1 || AVM_BYTE_EN !== 4'hF) begin
            n_fail++; $display("FAIL basic_rd_num busy=%0b rd=%0b addr=%0d be=%h want 1 1 1 f", BUSY, AVM_READ, AVM_ADDR, AVM_BYTE_EN); end
        wait_done(lat, tmo);
        n_checks++; if (tmo || lat != 11) begin n_fail++; $display("FAIL basic_latency got %0d want 11", lat); end
        n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL basic_busy_fin got %0b want 1", BUSY); end
        n_checks++; if (log_n - lbase != 10) begin n_fail++; $display("FAIL basic_count got %0d want 10", log_n - lbase); end
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (la[lbase + i] !== exp_a[i]) begin n_fail++; $display("FAIL basic_addr[%0d] got %0d want %0d", i, la[lbase + i], exp_a[i]); end
        end
        n_checks++; if (lw[lbase + 1] !== 1'b1 || ld[lbase + 1] !== 32'd1) begin n_fail++; $display("FAIL basic_wr_start wr=%0b data=%0d want 1 1", lw[lbase + 1], ld[lbase + 1]); end
        n_checks++; if (lw[lbase + 3] !== 1'b1 || ld[lbase + 3] !== 32'd0) begin n_fail++; $display("FAIL basic_wr_clr wr=%0b data=%0d want 1 0", lw[lbase + 3], ld[lbase + 3]); end
        @(negedge CLK);
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL basic_idle got %0b want 0", BUSY); end
        n_checks++; if (NUM_OUT !== 4'd2) begin n_fail++; $display("FAIL basic_num got %0d want 2", NUM_OUT); end
        n_checks++; if (ERROR !== 1'b0) begin n_fail++; $display("FAIL basic_error got %0b want 0", ERROR); end
        SH_IDX = 4'd2; SH_SEL = 2'd2; #1;
        n_checks++; if (SH_DATA !== 32'h1000_002D) begin n_fail++; $display("FAIL basic_sh_2z got %h want 1000002d", SH_DATA); end
        SH_IDX = 4'd1; SH_SEL = 2'd0; #1;
        n_checks++; if (SH_DATA !== 32'h1000_0018) begin n_fail++; $display("FAIL basic_sh_1x got %h want 10000018", SH_DATA); end
        SH_SEL = 2'd3; #1;
        n_checks++; if (SH_DATA !== 32'd0) begin n_fail++; $display("FAIL basic_sh_sel3 got %h want 0", SH_DATA); end
        SH_IDX = 4'd0; SH_SEL = 2'd0; #1;
        n_checks++; if (SH_DATA !== 32'd0) begin n_fail++; $display("FAIL basic_sh_idx0 got %h want 0", SH_DATA); end
        SH_IDX = 4'd11; #1;
        n_checks++; if (SH_DATA !== 32'd0) begin n_fail++; $display("FAIL basic_sh_idx11 got %h want 0", SH_DATA); end
    endtask

    task automatic test_clamp();
        int lat; bit tmo;
        num_val = 32'd15;
        start_step();
        wait_done(lat, tmo);
        n_checks++; if (tmo || lat != 35) begin n_fail++; $display("FAIL clamp_latency got %0d want 35", lat); end
        n_checks++; if (log_n - lbase != 34) begin n_fail++; $display("FAIL clamp_count got %0d want 34", log_n - lbase); end
        n_checks++; if (la[lbase + 33] !== 8'd53) begin n_fail++; $display("FAIL clamp_last_addr got %0d want 53", la[lbase + 33]); end
        n_checks++; if (NUM_OUT !== 4'd10) begin n_fail++; $display("FAIL clamp_num got %0d want 10", NUM_OUT); end
        SH_IDX = 4'd10; SH_SEL = 2'd2; #1;
        n_checks++; if (SH_DATA !== 32'h1000_0035) begin n_fail++; $display("FAIL clamp_sh_10z got %h want 10000035", SH_DATA); end
        SH_SEL = 2'd0; #1;
        n_checks++; if (SH_DATA !== 32'h1000_0021) begin n_fail++; $display("FAIL clamp_sh_10x got %h want 10000021", SH_DATA); end
    endtask

    task automatic test_stale();
        int lat; bit tmo;
        num_val = 32'd1; pos_bias = 32'h2000_0000;
        start_step();
        wait_done(lat, tmo);
        n_checks++; if (tmo || lat != 8) begin n_fail++; $display("FAIL stale_latency got %0d want 8", lat); end
        SH_IDX = 4'd1; SH_SEL = 2'd1; #1;
        n_checks++; if (SH_DATA !== 32'h2000_0022) begin n_fail++; $display("FAIL stale_sh_1y got %h want 20000022", SH_DATA); end
        SH_IDX = 4'd2; SH_SEL = 2'd0; #1;
        n_checks++; if (SH_DATA !== 32'h1000_0019) begin n_fail++; $display("FAIL stale_sh_2x got %h want 10000019", SH_DATA); end
        num_val = 32'd0;
        start_step();
        wait_done(lat, tmo);
        n_checks++; if (tmo || lat != 5) begin n_fail++; $display("FAIL zero_latency got %0d want 5", lat); end
        n_checks++; if (log_n - lbase != 4) begin n_fail++; $display("FAIL zero_count got %0d want 4", log_n - lbase); end
        pos_bias = 32'h1000_0000;
    endtask

    task automatic test_poll();
        int lat, polls; bit tmo;
        num_val = 32'd2; done_after = 3;
        start_step();
        wait_done(lat, tmo);
        n_checks++; if (tmo || lat != 26) begin n_fail++; $display("FAIL poll_latency got %0d want 26", lat); end
        polls = 0;
        for (int i = lbase; i < log_n; i++) if (la[i] == 8'd3) polls++;
        n_checks++; if (polls != 4) begin n_fail++; $display("FAIL poll_count got %0d want 4", polls); end
        done_after = 0;
    endtask

    task automatic test_waitreq();
        int lat; bit tmo;
        num_val = 32'd2;
        start_step();
        @(negedge CLK);
        AVM_WAITREQUEST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (AVM_WRITE !== 1'b1 || AVM_ADDR !== 8'd2 || AVM_WRITEDATA !== 32'd1) begin
                n_fail++; $display("FAIL wait_hold[%0d] wr=%0b addr=%0d data=%0d want 1 2 1", i, AVM_WRITE, AVM_ADDR, AVM_WRITEDATA); end
            if (i < 3) @(negedge CLK);
            if (i == 2) AVM_WAITREQUEST = 1'b0;
        end
        wait_done(lat, tmo);
        n_checks++; if (tmo || lat != 14) begin n_fail++; $display("FAIL wait_latency got %0d want 14", lat); end
    endtask

    task automatic test_back_to_back();
        int lat; bit tmo;
        num_val = 32'd2;
        start_step();
        @(negedge CLK); STEP_REQ = 1'b1;
        @(negedge CLK); STEP_REQ = 1'b0;
        wait_done(lat, tmo);
        n_checks++; if (tmo || lat != 11) begin n_fail++; $display("FAIL b2b_busy_req got %0d want 11", lat); end
        STEP_REQ = 1'b1;
        @(negedge CLK); STEP_REQ = 1'b0;
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL b2b_fin_req got %0b want 0", BUSY); end
        repeat (3) @(negedge CLK);
        n_checks++; if (log_n - lbase != 10) begin n_fail++; $display("FAIL b2b_count got %0d want 10", log_n - lbase); end
        start_step();
        wait_done(lat, tmo);
        n_checks++; if (tmo || lat != 11) begin n_fail++; $display("FAIL b2b_second got %0d want 11", lat); end
    endtask

    task automatic test_reset_mid();
        int snap; bit seen;
        num_val = 32'd10;
        start_step();
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (AVM_READ && AVM_ADDR >= 8'd24) seen = 1'b1;
            else @(negedge CLK);
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rst_reach_rdpos got 0 want 1"); end
        repeat (2) @(negedge CLK);
        RESET = 1'b1; STEP_REQ = 1'b1;
        @(negedge CLK);
        RESET = 1'b0; STEP_REQ = 1'b0;
        n_checks++; if ({AVM_READ, AVM_WRITE, AVM_BYTE_EN} !== 6'd0) begin n_fail++; $display("FAIL rst_bus got %b want 000000", {AVM_READ, AVM_WRITE, AVM_BYTE_EN}); end
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b want 0", BUSY); end
        SH_IDX = 4'd1; SH_SEL = 2'd0; #1;
        n_checks++; if (SH_DATA !== 32'd0) begin n_fail++; $display("FAIL rst_shadow got %h want 0", SH_DATA); end
        snap = log_n;
        repeat (5) @(negedge CLK);
        n_checks++; if (BUSY !== 1'b0 || log_n != snap) begin n_fail++; $display("FAIL rst_quiet busy=%0b new_txn=%0d want 0 0", BUSY, log_n - snap); end
    endtask

    task automatic test_timeout();
        int lat, posr; bit tmo;
        num_val = 32'd2; done_after = 100000;
`ifdef GRAVSIM_MASTER_TIMEOUT_EN
        start_step();
        wait_done(lat, tmo);
        n_checks++; if (tmo) begin n_fail++; $display("FAIL to_done got timeout want STEP_DONE"); end
        n_checks++; if (ERROR !== 1'b1) begin n_fail++; $display("FAIL to_error got %0b want 1", ERROR); end
        n_checks++; if (la[log_n - 1] !== 8'd2 || lw[log_n - 1] !== 1'b1 || ld[log_n - 1] !== 32'd0) begin
            n_fail++; $display("FAIL to_clr addr=%0d wr=%0b data=%0d want 2 1 0", la[log_n - 1], lw[log_n - 1], ld[log_n - 1]); end
        posr = 0;
        for (int i = lbase; i < log_n; i++) if (la[i] >= 8'd24) posr++;
        n_checks++; if (posr != 0) begin n_fail++; $display("FAIL to_pos_reads got %0d want 0", posr); end
        done_after = 0;
        start_step();
        n_checks++; if (ERROR !== 1'b0) begin n_fail++; $display("FAIL to_err_clear got %0b want 0", ERROR); end
        wait_done(lat, tmo);
        n_checks++; if (tmo || lat != 11) begin n_fail++; $display("FAIL to_next_latency got %0d want 11", lat); end
`else
        start_step();
        repeat (200) @(negedge CLK);
        n_checks++; if (BUSY !== 1'b1 || ERROR !== 1'b0) begin n_fail++; $display("FAIL nto_poll_forever busy=%0b err=%0b want 1 0", BUSY, ERROR); end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        done_after = 0;
        lat = 0; tmo = 1'b0; posr = 0;
`endif
    endtask

    initial begin
        RESET = 1'b1; STEP_REQ = 1'b0; AVM_WAITREQUEST = 1'b0;
        SH_IDX = 4'd0; SH_SEL = 2'd0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        test_reset();
        test_basic();
        test_clamp();
        test_stale();
        test_poll();
        test_waitreq();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
